// File: rtl/video_pkg.sv
// Shared types and constants for the video timing generator: the timing set
// struct, the 640x480 reset timing, character-cell geometry and handshake states.
package video_pkg;

  localparam int TIMING_W = 12;
  localparam int CHAR_W   = 6;
  localparam int CHAR_H   = 16;

  typedef struct packed {
    logic [TIMING_W-1:0] h_active;
    logic [TIMING_W-1:0] h_fp;
    logic [TIMING_W-1:0] h_sync;
    logic [TIMING_W-1:0] h_bp;
    logic [TIMING_W-1:0] v_active;
    logic [TIMING_W-1:0] v_fp;
    logic [TIMING_W-1:0] v_sync;
    logic [TIMING_W-1:0] v_bp;
  } timing_t;

  localparam timing_t TIMING_640X480 = '{
    h_active: 12'd640, h_fp: 12'd16, h_sync: 12'd96, h_bp: 12'd48,
    v_active: 12'd480, v_fp: 12'd10, v_sync: 12'd2,  v_bp: 12'd33
  };

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } hs_state_t;

endpackage

// File: rtl/video_axis_counter.sv
// One raster axis: a counter over 0..total-1 with active/sync window decode.
// Zero-length fields count as 1; the last count saturates at 2^CNT_W-1.
module video_axis_counter
  import video_pkg::*;
#(
  parameter int CNT_W = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             advance,
  input  logic [CNT_W-1:0] len_active,
  input  logic [CNT_W-1:0] len_fp,
  input  logic [CNT_W-1:0] len_sync,
  input  logic [CNT_W-1:0] len_bp,
  input  logic             load,
  output logic [CNT_W-1:0] cnt,
  output logic             active,
  output logic             sync,
  output logic             wrap
);

  localparam int WW = CNT_W + 2;
  localparam logic [WW-1:0] MAX_LAST = {2'b00, {CNT_W{1'b1}}};

  function automatic logic [WW-1:0] fix_len(input logic [CNT_W-1:0] v);
    return (v == '0) ? WW'(1) : {2'b00, v};
  endfunction

  logic [CNT_W-1:0] r_cnt;
  logic [WW-1:0]    w_sync_start, w_sync_end, w_last_wide, w_cnt_wide;
  logic [CNT_W-1:0] w_last;

  // Boundaries in a wider domain so oversized timings cannot overflow.
  assign w_sync_start = fix_len(len_active) + fix_len(len_fp);
  assign w_sync_end   = w_sync_start + fix_len(len_sync);
  assign w_last_wide  = w_sync_end + fix_len(len_bp) - WW'(1);
  assign w_last       = (w_last_wide > MAX_LAST) ? {CNT_W{1'b1}} : w_last_wide[CNT_W-1:0];
  assign w_cnt_wide   = {2'b00, r_cnt};

  assign cnt    = r_cnt;
  assign active = w_cnt_wide < fix_len(len_active);
  assign sync   = (w_cnt_wide >= w_sync_start) && (w_cnt_wide < w_sync_end);
  assign wrap   = (r_cnt == w_last);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (enable) begin
      if (load)         r_cnt <= '0;
      else if (advance) r_cnt <= wrap ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator with frame-synchronous timing reload handshake.
// Optional character-grid outputs are built when VTG_CHAR_GRID_EN is defined.
module video_timing_gen
  import video_pkg::*;
#(
  parameter int      CNT_W       = 12,
  parameter bit      HSYNC_POL   = 1'b1,
  parameter bit      VSYNC_POL   = 1'b1,
  parameter timing_t INIT_TIMING = TIMING_640X480
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  timing_t          timing,
  input  logic             timing_req,
  output logic             timing_ack,
  output logic             blank,
  output logic             hsync,
  output logic             vsync,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             line_start,
  output logic             frame_start,
`ifdef VTG_CHAR_GRID_EN
  output logic [6:0]       char_x,
  output logic [6:0]       char_y,
  output logic [2:0]       char_px,
  output logic [3:0]       char_py,
`endif
  output hs_state_t        dbg_state
);

  // timing_req/timing_ack: a request is sampled on any enabled edge where
  // timing_req=1; the latest request wins and is adopted on the last pixel of
  // the frame, which is also the edge that raises the single timing_ack pulse.
  hs_state_t        r_state, w_state_nxt;
  timing_t          r_cur, r_pend, w_cur_nxt, w_pend_nxt;
  logic             w_adopt, w_frame_end, w_vis;
  logic [CNT_W-1:0] w_hcnt, w_vcnt;
  logic             w_h_active, w_h_sync, w_h_wrap;
  logic             w_v_active, w_v_sync, w_v_wrap;
  logic             r_blank, r_hsync, r_vsync, r_line_start, r_frame_start, r_ack;
  logic [CNT_W-1:0] r_x, r_y;

  video_axis_counter #(.CNT_W(CNT_W)) u_h_axis (
    .clk(clk), .reset(reset), .enable(enable), .advance(1'b1),
    .len_active(CNT_W'(r_cur.h_active)), .len_fp(CNT_W'(r_cur.h_fp)),
    .len_sync(CNT_W'(r_cur.h_sync)), .len_bp(CNT_W'(r_cur.h_bp)),
    .load(w_adopt), .cnt(w_hcnt), .active(w_h_active), .sync(w_h_sync), .wrap(w_h_wrap)
  );

  video_axis_counter #(.CNT_W(CNT_W)) u_v_axis (
    .clk(clk), .reset(reset), .enable(enable), .advance(w_h_wrap),
    .len_active(CNT_W'(r_cur.v_active)), .len_fp(CNT_W'(r_cur.v_fp)),
    .len_sync(CNT_W'(r_cur.v_sync)), .len_bp(CNT_W'(r_cur.v_bp)),
    .load(w_adopt), .cnt(w_vcnt), .active(w_v_active), .sync(w_v_sync), .wrap(w_v_wrap)
  );

  assign w_frame_end = w_h_wrap && w_v_wrap;
  assign w_vis       = w_h_active && w_v_active;

  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur;
    w_pend_nxt  = r_pend;
    w_adopt     = 1'b0;
    // A request arriving on the frame-end cycle bypasses the pending register.
    if (w_frame_end && (r_state == ST_PENDING || timing_req)) begin
      w_adopt     = 1'b1;
      w_cur_nxt   = timing_req ? timing : r_pend;
      w_state_nxt = ST_IDLE;
    end else if (timing_req) begin
      w_pend_nxt  = timing;
      w_state_nxt = ST_PENDING;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cur   <= INIT_TIMING;
      r_pend  <= INIT_TIMING;
    end else if (enable) begin
      r_state <= w_state_nxt;
      r_cur   <= w_cur_nxt;
      r_pend  <= w_pend_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_blank       <= 1'b1;
      r_hsync       <= ~HSYNC_POL;
      r_vsync       <= ~VSYNC_POL;
      r_x           <= '0;
      r_y           <= '0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_ack         <= 1'b0;
    end else if (enable) begin
      r_blank       <= ~w_vis;
      r_hsync       <= w_h_sync ? HSYNC_POL : ~HSYNC_POL;
      r_vsync       <= w_v_sync ? VSYNC_POL : ~VSYNC_POL;
      r_x           <= w_vis ? w_hcnt : '0;
      r_y           <= w_vis ? w_vcnt : '0;
      r_line_start  <= (w_hcnt == '0) && w_v_active;
      r_frame_start <= (w_hcnt == '0) && (w_vcnt == '0);
      r_ack         <= w_adopt;
    end else begin
      // Frozen: levels hold, pulses are suppressed.
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_ack         <= 1'b0;
    end
  end

  assign blank       = r_blank;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign x           = r_x;
  assign y           = r_y;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
  assign timing_ack  = r_ack;
  assign dbg_state   = r_state;

`ifdef VTG_CHAR_GRID_EN
  logic [6:0] r_cx, r_cy, r_char_x, r_char_y;
  logic [2:0] r_px, r_char_px;
  logic [3:0] r_py, r_char_py;

  // r_cx/r_px and r_cy/r_py shadow hcnt/vcnt as quotient/remainder pairs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cx <= '0; r_px <= '0; r_cy <= '0; r_py <= '0;
      r_char_x <= '0; r_char_px <= '0; r_char_y <= '0; r_char_py <= '0;
    end else if (enable) begin
      if (w_h_wrap) begin
        r_px <= '0; r_cx <= '0;
      end else if (r_px == 3'(CHAR_W-1)) begin
        r_px <= '0; r_cx <= r_cx + 7'd1;
      end else begin
        r_px <= r_px + 3'd1;
      end
      if (w_frame_end) begin
        r_py <= '0; r_cy <= '0;
      end else if (w_h_wrap) begin
        if (r_py == 4'(CHAR_H-1)) begin
          r_py <= '0; r_cy <= r_cy + 7'd1;
        end else begin
          r_py <= r_py + 4'd1;
        end
      end
      r_char_x  <= w_vis ? r_cx : '0;
      r_char_px <= w_vis ? r_px : '0;
      r_char_y  <= w_vis ? r_cy : '0;
      r_char_py <= w_vis ? r_py : '0;
    end
  end

  assign char_x  = r_char_x;
  assign char_px = r_char_px;
  assign char_y  = r_char_y;
  assign char_py = r_char_py;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen: raster reference model compared
// every cycle, plus literal frame-period/pulse-width expectations.
module tb_video_timing_gen;
  import video_pkg::*;

  localparam bit HP = 1'b1;
  localparam bit VP = 1'b0;
  localparam timing_t T_INIT = '{12'd20, 12'd3, 12'd4, 12'd5, 12'd6, 12'd2, 12'd2, 12'd3};
  localparam timing_t T_A    = '{12'd16, 12'd1, 12'd2, 12'd1, 12'd5, 12'd1, 12'd1, 12'd1};
  localparam timing_t T_B    = '{12'd10, 12'd2, 12'd3, 12'd4, 12'd4, 12'd1, 12'd2, 12'd1};
  localparam timing_t T_Z    = '{12'd8,  12'd0, 12'd0, 12'd0, 12'd3, 12'd0, 12'd1, 12'd0};
  localparam timing_t T_C    = '{12'd4000, 12'd100, 12'd0, 12'd0, 12'd1, 12'd0, 12'd0, 12'd0};

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst_n, en, req;
  timing_t tmg;
  logic timing_ack, blank, hsync, vsync, line_start, frame_start;
  logic [11:0] x, y;
  hs_state_t dbg_state;
`ifdef VTG_CHAR_GRID_EN
  logic [6:0] char_x, char_y;
  logic [2:0] char_px;
  logic [3:0] char_py;
`endif

  always #5 clk = ~clk;

  video_timing_gen #(.CNT_W(12), .HSYNC_POL(HP), .VSYNC_POL(VP), .INIT_TIMING(T_INIT)) dut (
    .clk(clk), .reset(rst_n), .enable(en), .timing(tmg), .timing_req(req),
    .timing_ack(timing_ack), .blank(blank), .hsync(hsync), .vsync(vsync),
    .x(x), .y(y), .line_start(line_start), .frame_start(frame_start),
`ifdef VTG_CHAR_GRID_EN
    .char_x(char_x), .char_y(char_y), .char_px(char_px), .char_py(char_py),
`endif
    .dbg_state(dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int mh, mv, ha, hf, hs, hb, va, vf, vs, vb, hl, vl;
  timing_t mcur, mpend;
  bit mpv, mvalid, fe, vis;
  logic e_blank, e_hs, e_vs, e_ls, e_fs, e_ack;
  int e_x, e_y, e_cx, e_cy, e_px, e_py;

  function automatic int fx(input logic [11:0] v);
    return (v == 0) ? 1 : int'(v);
  endfunction

  initial mvalid = 0;

  always @(posedge clk) begin
    mvalid = 1;
    if (!rst_n) begin
      mh = 0; mv = 0; mcur = T_INIT; mpv = 0;
      e_blank = 1; e_hs = !HP; e_vs = !VP; e_x = 0; e_y = 0;
      e_ls = 0; e_fs = 0; e_ack = 0; e_cx = 0; e_cy = 0; e_px = 0; e_py = 0;
    end else if (en) begin
      ha = fx(mcur.h_active); hf = fx(mcur.h_fp); hs = fx(mcur.h_sync); hb = fx(mcur.h_bp);
      va = fx(mcur.v_active); vf = fx(mcur.v_fp); vs = fx(mcur.v_sync); vb = fx(mcur.v_bp);
      hl = ha + hf + hs + hb - 1; if (hl > 4095) hl = 4095;
      vl = va + vf + vs + vb - 1; if (vl > 4095) vl = 4095;
      vis     = (mh < ha) && (mv < va);
      e_blank = !vis;
      e_hs    = (mh >= ha + hf && mh < ha + hf + hs) ? HP : !HP;
      e_vs    = (mv >= va + vf && mv < va + vf + vs) ? VP : !VP;
      e_x     = vis ? mh : 0;
      e_y     = vis ? mv : 0;
      e_cx    = (e_x / 6) % 128; e_px = e_x % 6;
      e_cy    = (e_y / 16) % 128; e_py = e_y % 16;
      e_ls    = (mh == 0) && (mv < va);
      e_fs    = (mh == 0) && (mv == 0);
      fe      = (mh == hl) && (mv == vl);
      e_ack   = fe && (mpv || req);
      if (fe) begin
        if (req) mcur = tmg;
        else if (mpv) mcur = mpend;
        mpv = 0; mh = 0; mv = 0;
      end else begin
        if (req) begin mpend = tmg; mpv = 1; end
        if (mh == hl) begin mh = 0; mv = mv + 1; end
        else mh = mh + 1;
      end
    end else begin
      e_ls = 0; e_fs = 0; e_ack = 0;
    end
  end

  // ---------------- scoreboard / monitor ----------------
  int cyc = 0, last_fs = 0, fs_period = 0, ls_acc = 0, ls_last = 0;
  int ack_cnt = 0, ack_cyc = 0, hs_run = 0, hs_last = 0, vs_run = 0, vs_last = 0;

  always @(negedge clk) begin
    cyc++;
    if (mvalid) begin
      chk("blank", blank, e_blank);
      chk("hsync", hsync, e_hs);
      chk("vsync", vsync, e_vs);
      chk("x", x, e_x);
      chk("y", y, e_y);
      chk("line_start", line_start, e_ls);
      chk("frame_start", frame_start, e_fs);
      chk("timing_ack", timing_ack, e_ack);
      chk("pending_state", dbg_state, mpv);
`ifdef VTG_CHAR_GRID_EN
      chk("char_x", char_x, e_cx);
      chk("char_px", char_px, e_px);
      chk("char_y", char_y, e_cy);
      chk("char_py", char_py, e_py);
`endif
    end
    if (frame_start === 1'b1) begin
      fs_period = cyc - last_fs; last_fs = cyc; ls_last = ls_acc; ls_acc = 0;
    end
    if (line_start === 1'b1) ls_acc++;
    if (timing_ack === 1'b1) begin ack_cnt++; ack_cyc = cyc; end
    if (hsync === HP) hs_run++;
    else if (hs_run != 0) begin hs_last = hs_run; hs_run = 0; end
    if (vsync === VP) vs_run++;
    else if (vs_run != 0) begin vs_last = vs_run; vs_run = 0; end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic req_timing(input timing_t t);
    tmg = t; req = 1'b1;
    step();
    req = 1'b0;
  endtask

  task automatic wait_fs(input int budget);
    for (int i = 0; i < budget; i++) begin
      step();
      if (frame_start === 1'b1) return;
    end
    n_vec++; n_err++;
    $display("FAIL wait_frame_start: no frame_start within %0d cycles", budget);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_blank"}, blank, 1);
    chk({tag, "_hsync"}, hsync, 0);
    chk({tag, "_vsync"}, vsync, 1);
    chk({tag, "_x"}, x, 0);
    chk({tag, "_y"}, y, 0);
    chk({tag, "_ls"}, line_start, 0);
    chk({tag, "_fs"}, frame_start, 0);
    chk({tag, "_ack"}, timing_ack, 0);
  endtask

  timing_t rnd_tab [4];

  initial begin
    rnd_tab[0] = T_INIT; rnd_tab[1] = T_A; rnd_tab[2] = T_B; rnd_tab[3] = T_Z;
    rst_n = 1'b0; en = 1'b1; req = 1'b0; tmg = T_INIT;
    repeat (3) step();
    chk_reset_outputs("reset");

    // Release: frame_start is the first pulse, one cycle after release.
    rst_n = 1'b1;
    step();
    chk("fs_after_release", frame_start, 1);
    wait_fs(600);
    chk("init_period", fs_period, 416);
    chk("init_line_starts", ls_last, 6);
    wait_fs(600);
    chk("init_hsync_width", hs_last, 4);
    chk("init_vsync_width", vs_last, 64);

    // Mid-frame request: current frame completes, one ack on its last pixel.
    repeat (50) step();
    ack_cnt = 0;
    req_timing(T_A);
    wait_fs(600);
    chk("old_frame_period", fs_period, 416);
    chk("single_ack", ack_cnt, 1);
    chk("ack_before_fs", last_fs - ack_cyc, 1);
    wait_fs(400);
    chk("new_frame_period", fs_period, 160);
    chk("new_line_starts", ls_last, 5);

    // Two requests in one frame: last one wins, still one ack.
    repeat (10) step();
    ack_cnt = 0;
    req_timing(T_B);
    repeat (30) step();
    req_timing(T_Z);
    wait_fs(400);
    chk("two_req_period", fs_period, 160);
    chk("two_req_acks", ack_cnt, 1);
    wait_fs(400);
    chk("zero_field_period", fs_period, 66);
    chk("zero_field_line_starts", ls_last, 3);

    // Freeze for 100 cycles inside a frame: the frame stretches by 100.
    repeat (3) step();
    en = 1'b0;
    repeat (100) step();
    en = 1'b1;
    wait_fs(400);
    chk("frozen_period", fs_period, 166);

    // Random enable gaps and timing requests against the model.
    for (int i = 0; i < 15000; i++) begin
      en  = ($urandom_range(0, 7) != 0);
      req = ($urandom_range(0, 149) == 0);
      tmg = rnd_tab[$urandom_range(0, 3)];
      step();
    end
    en = 1'b1; req = 1'b0;

    // Oversized horizontal total saturates at 4095 (4096 cycles per line).
    req_timing(T_C);
    wait_fs(3000);
    wait_fs(20000);
    chk("clamped_period", fs_period, 16384);

    // Reset mid-frame with a pending request: request is discarded.
    repeat (100) step();
    req_timing(T_A);
    repeat (50) step();
    rst_n = 1'b0;
    step(); step();
    chk_reset_outputs("midreset");
    ack_cnt = 0;
    rst_n = 1'b1;
    step();
    chk("fs_after_midreset", frame_start, 1);
    wait_fs(600);
    chk("post_reset_period", fs_period, 416);
    wait_fs(600);
    chk("pending_discarded_period", fs_period, 416);
    chk("pending_discarded_acks", ack_cnt, 0);

    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 SHALL have parameters: CNT_W, default 12, width of all counters and coordinates; HSYNC_POL, default 1, active level of hsync; VSYNC_POL, default 1, active level of vsync; INIT_TIMING, default 640x480 (h 640/16/96/48, v 480/10/2/33), reset timing set.
REQ-002 SHALL have ports:
  clk  in  1  pixel clock, the single clock;
  reset  in  1  synchronous, active-low reset;
  enable  in  1  run counters when 1, freeze all state when 0;
  timing  in  timing_t  new timing set (active/front porch/sync/back porch, horizontal and vertical);
  timing_req  in  1  request to load timing;
  timing_ack  out  1  one-cycle pulse when timing is adopted;
  blank  out  1  1 outside the active area;
  hsync  out  1  horizontal sync at HSYNC_POL;
  vsync  out  1  vertical sync at VSYNC_POL;
  x  out  CNT_W  active pixel column, 0 when blanked;
  y  out  CNT_W  active line, 0 when blanked;
  line_start  out  1  pulse on the first active pixel of each active line;
  frame_start  out  1  pulse on pixel (0,0).

Function
REQ-003 SHALL run a free horizontal counter hcnt over 0..H_TOTAL-1, where H_TOTAL = active+fp+sync+bp, and a vertical counter vcnt that advances on hcnt wrap over 0..V_TOTAL-1.
REQ-004 SHALL register all outputs with 1-cycle latency from the hcnt/vcnt state they decode.
REQ-005 SHALL set blank=1 iff hcnt>=H_ACTIVE or vcnt>=V_ACTIVE.
REQ-006 SHALL assert hsync for H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC, and vsync for the equivalent vcnt window; it SHALL apply each polarity after decode.
REQ-007 SHALL make x and y equal hcnt and vcnt when not blanked.
REQ-008 SHALL assert frame_start for exactly one cycle per frame, and line_start for exactly V_ACTIVE cycles per frame.
REQ-009 SHALL use the following timing handshake:
  - when timing_req=1, latch timing into a pending register;
  - hold pending until the last pixel of the frame (hcnt=H_TOTAL-1, vcnt=V_TOTAL-1);
  - on that cycle, adopt the pending timing, restart from (0,0), and pulse timing_ack.
REQ-010 SHALL hold state IDLE or PENDING:
  - IDLE to PENDING on timing_req;
  - PENDING to IDLE at frame end;
  - a timing_req in PENDING overwrites pending (last wins) with no extra ack;
  - a timing_req on the frame-end cycle itself is adopted on that edge.
REQ-011 SHALL, when enable=0, hold counters and all outputs at their last value, hold the handshake, and emit no pulses; it SHALL resume from the same point.
REQ-012 SHALL treat any timing field of 0 as 1, and SHALL clamp totals exceeding 2^CNT_W-1 to wrap at 2^CNT_W-1, never overflowing.

Reset
REQ-013 SHALL, on reset=0 at a clk edge, do all of the following:
  - set hcnt=vcnt=0 and load INIT_TIMING;
  - enter IDLE;
  - drive blank=1, hsync=!HSYNC_POL, vsync=!VSYNC_POL, x=y=0, and line_start=frame_start=timing_ack=0.
REQ-014 SHALL give reset priority over enable and timing_req, discarding any pending request, including one that arrives mid-frame.
REQ-015 SHALL produce frame_start as the first output pulse after reset release, on the second cycle.

Configuration
REQ-016 SHALL, with VTG_CHAR_GRID_EN defined, add outputs char_x and char_y (7 bits each) plus char_px (3 bits) and char_py (4 bits):
  - cell size is 6x8 pixels, with vertical double-scan making each cell 16 lines high;
  - char_x = x/6, char_px = x%6;
  - char_y = y/16, char_py = y%16;
  - all four are computed incrementally (no dividers), aligned with x/y, and 0 when blanked.
REQ-017 SHALL, without VTG_CHAR_GRID_EN, not declare these ports and SHALL have no grid logic.

Structure
REQ-018 SHALL place timing_t (packed struct of eight CNT_W fields), the 640x480 constant TIMING_640X480, and the cell constants CHAR_W=6 and CHAR_H=16 in package video_pkg.
REQ-019 SHALL implement each axis with one sub-module, video_axis_counter, instanced twice. Its ports are:
  - in: clk, reset, enable, advance, per-axis timing fields, load;
  - out: cnt, active, sync, wrap.

Verification
REQ-020 Reset, then 800x525 frames with enable=1:
  - hsync high for hcnt 656..751 (96 cycles);
  - vsync high for lines 490..491;
  - frame period 420000 cycles;
  - line_start count 480 per frame.
REQ-021 HSYNC_POL=0, VSYNC_POL=0: both syncs idle high; low pulses of the same widths as REQ-020.
REQ-022 Drive timing_req with 1280x720 timing (h 1280/110/40/220, v 720/5/5/20) mid-frame:
  - the current frame finishes at 800x525;
  - timing_ack is seen once on the final pixel;
  - the next frame period is 1237500 cycles.
REQ-023 Two timing_req in one frame (640x480, then 800x600): one ack, and 800x600 is adopted.
REQ-024 enable=0 for 100 cycles at hcnt=300: all outputs frozen; after release, hsync starts exactly 100 cycles later than nominal.
REQ-025 With VTG_CHAR_GRID_EN, at pixel x=13, y=37: char_x=2, char_px=1, char_y=2, char_py=5; reset asserted mid-line returns all outputs to reset values the next cycle.
